// File: rtl/axi_ic_pkg.sv
// -----------------------------------------------------------------------------
// axi_ic_pkg
//   Shared definitions for the 4-master AXI interconnect control path:
//   write/read scheduler FSM state encoding, master count, arbitration-type
//   constants and the Round-Robin search-start helper.
// -----------------------------------------------------------------------------
package axi_ic_pkg;

    localparam int NUM_MST = 4;

    // Arbitration policy selector values.
    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Transaction phases of a write (and read) scheduler.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_t;

    // Round-Robin search start for a one-hot previous winner: the index after
    // the last winner, wrapping 3->0. No previous winner starts at 0.
    function automatic logic [1:0] rr_start_idx(input logic [NUM_MST-1:0] last_winner);
        case (last_winner)
            4'b0001: return 2'd1;
            4'b0010: return 2'd2;
            4'b0100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_wr_arb_ctrl_if.sv
// -----------------------------------------------------------------------------
// axi_wr_arb_ctrl_if
//   Control-side view of the write path between the four masters and the
//   shared slave write port.
//
//   Signals:
//     m_awvalid / m_awready  per-master AW handshake (4 bits each)
//     s_awvalid / s_awready  AW handshake toward the shared slave port
//     s_wvalid/s_wready/s_wlast  observed W handshake on the muxed channel
//     s_bvalid / s_bready    observed B handshake on the muxed channel
//     grant                  one-hot mux select for AW/W/B (0 when idle)
//     aw_en / w_en / b_en    phase enables for the datapath gating
//
//   Modports:
//     master : the scheduler (drives ready/valid toward slave, grant, enables)
//     slave  : the surrounding datapath / environment
// -----------------------------------------------------------------------------
interface axi_wr_arb_ctrl_if;
    import axi_ic_pkg::*;

    logic [NUM_MST-1:0] m_awvalid;
    logic [NUM_MST-1:0] m_awready;
    logic               s_awvalid;
    logic               s_awready;
    logic               s_wvalid;
    logic               s_wready;
    logic               s_wlast;
    logic               s_bvalid;
    logic               s_bready;
    logic [NUM_MST-1:0] grant;
    logic               aw_en;
    logic               w_en;
    logic               b_en;

    modport master (
        input  m_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
        output m_awready, s_awvalid, grant, aw_en, w_en, b_en
    );

    modport slave (
        output m_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
        input  m_awready, s_awvalid, grant, aw_en, w_en, b_en
    );

endinterface

// File: rtl/arb_pick4.sv
// -----------------------------------------------------------------------------
// arb_pick4
//   Combinational 4-way winner selection shared by the write and read
//   schedulers.
//
//   Ports:
//     req          in  4  request vector
//     last_winner  in  4  one-hot previous winner (0 = none yet)
//     arb_type     in  1  ARB_RR (0) or ARB_FIXED (1, index 0 highest)
//     winner       out 4  one-hot winner, 0 when req is 0
// -----------------------------------------------------------------------------
module arb_pick4
    import axi_ic_pkg::*;
(
    input  logic [NUM_MST-1:0] req,
    input  logic [NUM_MST-1:0] last_winner,
    input  logic               arb_type,
    output logic [NUM_MST-1:0] winner
);

    logic [1:0] start;
    logic [1:0] idx;
    logic       found;

    assign start = rr_start_idx(last_winner);

    // NOTE: every variable written in a combinational block gets a value on
    // entry; a path that leaves one unassigned would infer a latch.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        if (arb_type == ARB_FIXED) begin
            // Isolate the lowest set bit.
            winner = req & (~req + 4'd1);
        end else begin
            // Walk the ring from the start index; the 2-bit index wraps 3->0.
            for (int k = 0; k < NUM_MST; k++) begin
                idx = start + 2'(k);
                if (!found && req[idx]) begin
                    winner[idx] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_wr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// axi_wr_arb_ctrl
//   Write-path scheduler for the 4-master AXI interconnect. Picks one master's
//   AW request (Round-Robin or Fixed-Priority), then locks the grant across the
//   AW handshake, the W burst and the B response while driving the mux select
//   and phase enables the write datapath uses.
//
//   Parameters:
//     TIMEOUT_CYC  watchdog limit in cycles (optional feature only)
//     CNT_W        width of the completed-transaction counter
//
//   Ports:
//     clk           in   system clock
//     rst_n         in   asynchronous active-low reset
//     arbiter_type  in   0 = Round-Robin, 1 = Fixed Priority; sampled in IDLE
//     bus           if   axi_wr_arb_ctrl_if.master (handshakes, grant, enables)
//     busy          out  high in any state other than IDLE
//     txn_cnt       out  completed-transaction count, wraps at 2^CNT_W
//     timeout_err   out  one-cycle watchdog pulse (0 unless feature enabled)
//
//   Optional feature macro: AXI_WR_ARB_TIMEOUT_EN
//     Adds a watchdog that aborts a transaction making no progress for
//     TIMEOUT_CYC cycles. Undefined: no counter, timeout_err tied 0.
// -----------------------------------------------------------------------------
module axi_wr_arb_ctrl
    import axi_ic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arbiter_type,
    axi_wr_arb_ctrl_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt,
    output logic             timeout_err
);

    // A watchdog limit below two cycles has no meaningful compare value; such
    // a configuration elaborates this marker block so it shows in the hierarchy.
    if (TIMEOUT_CYC < 2) begin : g_invalid_timeout_cyc
    end

    wr_state_t          state_q, state_d;
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [NUM_MST-1:0] last_q,  last_d;
    logic [NUM_MST-1:0] winner;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic aw_phase, w_phase, b_phase;
    logic aw_fire, w_fire, w_last_fire, b_fire;
    logic wd_expire;

    arb_pick4 u_pick (
        .req         (bus.m_awvalid),
        .last_winner (last_q),
        .arb_type    (arbiter_type),
        .winner      (winner)
    );

    // Phase enables decode straight from the state register, so they are
    // glitch-free and drop with the asynchronous reset.
    assign aw_phase = (state_q == ADDR);
    assign w_phase  = (state_q == DATA);
    assign b_phase  = (state_q == RESP);
    assign busy     = (state_q != IDLE);

    assign bus.aw_en     = aw_phase;
    assign bus.w_en      = w_phase;
    assign bus.b_en      = b_phase;
    assign bus.grant     = grant_q;
    assign bus.s_awvalid = aw_phase & |(bus.m_awvalid & grant_q);
    assign bus.m_awready = aw_phase ? (grant_q & {NUM_MST{bus.s_awready}}) : '0;
    assign txn_cnt       = cnt_q;

    // W/B handshakes are qualified by phase: a W beat presented before the AW
    // handshake is not routed and must not advance the FSM.
    assign aw_fire     = bus.s_awvalid & bus.s_awready;
    assign w_fire      = w_phase & bus.s_wvalid & bus.s_wready;
    assign w_last_fire = w_fire & bus.s_wlast;
    assign b_fire      = b_phase & bus.s_bvalid & bus.s_bready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.m_awvalid) begin
                    grant_d = winner;
                    state_d = ADDR;
                end else begin
                    grant_d = '0;
                end
            end
            ADDR: if (aw_fire)     state_d = DATA;
            DATA: if (w_last_fire) state_d = RESP;
            RESP: begin
                if (b_fire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = grant_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // An aborted transaction still counts as the last winner so that
        // Round-Robin moves past the stalled master; it is not counted done.
        if (wd_expire) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = grant_q;
            cnt_d   = cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef AXI_WR_ARB_TIMEOUT_EN
    localparam int unsigned     WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q;
    logic            progress;

    // Any handshake that moves the FSM, or any W beat, is progress; the
    // watchdog only fires on a cycle with none of them.
    assign progress  = aw_fire | w_last_fire | b_fire | w_fire;
    assign wd_expire = busy & (wd_q == WD_LAST) & ~progress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if ((state_d != state_q) || w_fire) begin
            wd_q <= '0;
        end else if (busy) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    assign timeout_err = wd_expire;

endmodule
